icache_nway: RTL and testbench

- Parametrised successor to the team's fixed 2-way, 256-set, 16-byte-line instruction cache.
- Generalised in ways, sets and line length.
- New behaviour: hit-under-hit pipelining, word-serial burst refill, invalid-way-first / per-set round-robin replacement, and an index-invalidate port for the CACHE instruction.
- Sits between IF stage and the AXI bridge read channel.

---
 rtl/icache_nway.sv | 234 +++++++++++++++++++++++
 tb/tb_icache_nway.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// Parametrised N-way instruction cache with hit-under-hit pipelining, word-serial line refill,
// invalid-first / per-set round-robin replacement and an index-invalidate port.
module icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    valid,
    input  logic                    uncache,
    input  logic [31:0]             addr,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             rdata,
    input  logic                    inv_valid,
    input  logic [$clog2(SETS)-1:0] inv_index,
    output logic                    inv_ok,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [31:0]             rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [31:0]             ret_data
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_t;

    state_t             state_q, state_d;
    logic               rbUncache_q;
    logic [TAG_W-1:0]   rbTag_q;
    logic [IDX_W-1:0]   rbIndex_q;
    logic [WORD_W-1:0]  rbOff_q;

    logic [TAG_W-1:0]   tagMem   [WAYS][SETS];
    logic [LINE_W-1:0]  dataMem  [WAYS][SETS];
    logic [TAG_W-1:0]   tagRd_q  [WAYS];
    logic [LINE_W-1:0]  dataRd_q [WAYS];
    logic [SETS-1:0]    valid_q  [WAYS];
    logic [WAY_W-1:0]   rr_q     [SETS];

    logic [WAY_W-1:0]   victim_q;
    logic               victimRr_q;
    logic [WORD_W-1:0]  beat_q;
    logic [31:0]        result_q;
    logic [LINE_W-1:0]  lineBuf_q;

    logic [WAYS-1:0]    match;
    logic               hit;
    logic [31:0]        hitWord;
    logic [WAY_W-1:0]   victim;
    logic               allValid;
    logic [LINE_W-1:0]  fillLine;
    logic [31:0]        reqWord;
    logic               fillCached;
    logic [IDX_W-1:0]   addrIndex;
    logic               unusedAddr;

    assign addrIndex  = addr[OFF_W +: IDX_W];
    assign unusedAddr = ^addr[1:0];

    // Descending scan so the lowest-numbered invalid way wins the victim choice.
    always_comb begin
        match    = '0;
        hitWord  = '0;
        victim   = rr_q[rbIndex_q];
        allValid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match[w] = valid_q[w][rbIndex_q] && (tagRd_q[w] == rbTag_q);
            if (match[w]) begin
                hitWord = hitWord | dataRd_q[w][{rbOff_q, 5'b0} +: 32];
            end
            if (!valid_q[w][rbIndex_q]) begin
                victim   = WAY_W'(w);
                allValid = 1'b0;
            end
        end
        hit = !rbUncache_q && $onehot(match);
    end

    always_comb begin
        fillLine = lineBuf_q;
        fillLine[{beat_q, 5'b0} +: 32] = ret_data;
        reqWord  = (rbUncache_q || beat_q == rbOff_q) ? ret_data : result_q;
    end

    assign rd_type = rbUncache_q ? 3'b010 : 3'b100;
    assign rd_addr = rbUncache_q ? {rbTag_q, rbIndex_q, rbOff_q, 2'b00}
                                 : {rbTag_q, rbIndex_q, {OFF_W{1'b0}}};

    always_comb begin
        state_d = state_q;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        inv_ok  = 1'b0;
        rd_req  = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                if (inv_valid) begin
                    inv_ok = 1'b1;
                end else if (valid) begin
                    addr_ok = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = hitWord;
                    if (valid && !inv_valid) begin
                        addr_ok = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                rd_req = 1'b1;
                if (rd_rdy) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (ret_valid && ret_last) begin
                    data_ok = 1'b1;
                    rdata   = reqWord;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!resetn) begin
            state_d = IDLE;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            inv_ok  = 1'b0;
            rd_req  = 1'b0;
            rdata   = '0;
        end
    end

    assign fillCached = (state_q == REFILL) && ret_valid && ret_last && !rbUncache_q && resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rbUncache_q <= 1'b0;
            rbTag_q     <= '0;
            rbIndex_q   <= '0;
            rbOff_q     <= '0;
            victim_q    <= '0;
            victimRr_q  <= 1'b0;
        end else begin
            if (addr_ok) begin
                rbUncache_q <= uncache;
                rbTag_q     <= addr[31 -: TAG_W];
                rbIndex_q   <= addrIndex;
                rbOff_q     <= addr[2 +: WORD_W];
            end
            if (state_q == LOOKUP && state_d == MISS) begin
                victim_q   <= victim;
                victimRr_q <= allValid;
            end
        end
    end

    // Tag/data arrays are plain RAMs; stale contents are masked by the cleared valid bits.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (addr_ok) begin
                tagRd_q[w]  <= tagMem[w][addrIndex];
                dataRd_q[w] <= dataMem[w][addrIndex];
            end
            if (fillCached && victim_q == WAY_W'(w)) begin
                tagMem[w][rbIndex_q]  <= rbTag_q;
                dataMem[w][rbIndex_q] <= fillLine;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            if (inv_ok) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][inv_index] <= 1'b0;
                end
            end
            if (fillCached) begin
                valid_q[victim_q][rbIndex_q] <= 1'b1;
                if (victimRr_q) begin
                    rr_q[rbIndex_q] <= rr_q[rbIndex_q] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_q    <= '0;
            result_q  <= '0;
            lineBuf_q <= '0;
        end else if (state_q == REFILL && ret_valid) begin
            lineBuf_q[{beat_q, 5'b0} +: 32] <= ret_data;
            if (beat_q == rbOff_q) begin
                result_q <= ret_data;
            end
            beat_q <= ret_last ? '0 : beat_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (WAYS=2, SETS=256, LINE_WORDS=4).
// Inputs change on the falling edge and outputs are checked 1 ns later.
module tb_icache_nway;
    logic        clk;
    logic        resetn;
    logic        valid;
    logic        uncache;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        inv_valid;
    logic [7:0]  inv_index;
    logic        inv_ok;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int testCount = 0;
    int failCount = 0;

    icache_nway #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .uncache   (uncache),
        .addr      (addr),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .inv_valid (inv_valid),
        .inv_index (inv_index),
        .inv_ok    (inv_ok),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate assertion comparing one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Moves to the next falling edge and presents a fetch request (or none).
    task automatic applyStimulus(input logic v, input logic u, input logic [31:0] a);
        @(negedge clk);
        valid   = v;
        uncache = u;
        addr    = a;
        #1;
    endtask

    task automatic fetchHit(input string tag, input logic [31:0] a, input logic [31:0] expWord);
        applyStimulus(1'b1, 1'b0, a);
        checkOutput({tag, " addr_ok"}, addr_ok, 1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput({tag, " hit data_ok"}, data_ok, 1);
        checkOutput({tag, " hit rdata"}, rdata, expWord);
    endtask

    // Full miss: request, lookup miss, held rd_req, then nBeats return beats starting at base.
    task automatic missFill(input string tag, input logic [31:0] a, input logic u,
                            input logic [31:0] expAddr, input logic [2:0] expType,
                            input int nBeats, input logic [31:0] base, input logic [31:0] expWord);
        applyStimulus(1'b1, u, a);
        checkOutput({tag, " addr_ok"}, addr_ok, 1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput({tag, " lookup miss data_ok"}, data_ok, 0);
        @(negedge clk); #1;
        checkOutput({tag, " rd_req"}, rd_req, 1);
        checkOutput({tag, " rd_addr"}, rd_addr, expAddr);
        checkOutput({tag, " rd_type"}, {29'b0, rd_type}, {29'b0, expType});
        @(negedge clk);
        rd_rdy = 1'b1;
        #1;
        checkOutput({tag, " rd_req held"}, rd_req, 1);
        checkOutput({tag, " rd_addr held"}, rd_addr, expAddr);
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            ret_valid = 1'b1;
            ret_data  = base + i;
            ret_last  = (i == nBeats - 1);
            #1;
            if (i == nBeats - 1) begin
                checkOutput({tag, " last beat data_ok"}, data_ok, 1);
                checkOutput({tag, " last beat rdata"}, rdata, expWord);
            end else begin
                checkOutput({tag, " early beat data_ok"}, data_ok, 0);
            end
            @(negedge clk);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        #1;
        checkOutput({tag, " after fill data_ok"}, data_ok, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        valid     = 1'b1;
        uncache   = 1'b0;
        addr      = 32'h0000_1000;
        inv_valid = 1'b0;
        inv_index = 8'h00;
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = 32'h0;

        // Reset state, with a request pending that must not be accepted.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset addr_ok", addr_ok, 0);
        checkOutput("reset data_ok", data_ok, 0);
        checkOutput("reset inv_ok", inv_ok, 0);
        checkOutput("reset rd_req", rd_req, 0);
        checkOutput("reset rdata", rdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        valid  = 1'b0;

        // Cold miss on a cached line, then a refetch hit.
        missFill("cold", 32'h0000_1008, 1'b0, 32'h0000_1000, 3'b100, 4, 32'hA0, 32'hA2);
        fetchHit("refetch", 32'h0000_1004, 32'hA1);

        // Back-to-back hits across the whole line.
        applyStimulus(1'b1, 1'b0, 32'h0000_1000);
        checkOutput("b2b addr_ok 0", addr_ok, 1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_1000 + 4 * i);
            checkOutput("b2b addr_ok", addr_ok, 1);
            checkOutput("b2b data_ok", data_ok, 1);
            checkOutput("b2b rdata", rdata, 32'hA0 + i - 1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("b2b last data_ok", data_ok, 1);
        checkOutput("b2b last rdata", rdata, 32'hA3);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("b2b idle data_ok", data_ok, 0);

        // Replacement in index 5: T0->way0, T1->way1, T2 evicts way0 via rr.
        missFill("T0 fill", 32'h0001_0050, 1'b0, 32'h0001_0050, 3'b100, 4, 32'h100, 32'h100);
        missFill("T1 fill", 32'h0002_0054, 1'b0, 32'h0002_0050, 3'b100, 4, 32'h200, 32'h201);
        missFill("T2 fill", 32'h0003_005C, 1'b0, 32'h0003_0050, 3'b100, 4, 32'h300, 32'h303);
        fetchHit("T1 hit", 32'h0002_0058, 32'h202);
        fetchHit("T2 hit", 32'h0003_0050, 32'h300);
        missFill("T0 miss", 32'h0001_0054, 1'b0, 32'h0001_0050, 3'b100, 4, 32'h400, 32'h401);
        missFill("T1 evicted", 32'h0002_0050, 1'b0, 32'h0002_0050, 3'b100, 4, 32'h500, 32'h500);

        // Uncached single-beat fetch, then the same address cached must miss.
        missFill("uncached", 32'h1FC0_0004, 1'b1, 32'h1FC0_0004, 3'b010, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        missFill("uc cached", 32'h1FC0_0004, 1'b0, 32'h1FC0_0000, 3'b100, 4, 32'hC0, 32'hC1);

        // Invalidate wins over a simultaneous fetch; the fetch is accepted next cycle and misses.
        @(negedge clk);
        inv_valid = 1'b1;
        inv_index = 8'h00;
        valid     = 1'b1;
        addr      = 32'h0000_1000;
        #1;
        checkOutput("inv inv_ok", inv_ok, 1);
        checkOutput("inv addr_ok", addr_ok, 0);
        @(negedge clk);
        inv_valid = 1'b0;
        #1;
        checkOutput("inv next addr_ok", addr_ok, 1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("inv lookup miss", data_ok, 0);
        @(negedge clk); #1;
        checkOutput("inv rd_req", rd_req, 1);
        checkOutput("inv rd_addr", rd_addr, 32'h0000_1000);
        rd_rdy = 1'b1;

        // Reset after two refill beats discards the partial line.
        @(negedge clk);
        rd_rdy    = 1'b0;
        ret_valid = 1'b1;
        ret_data  = 32'hE0;
        @(negedge clk);
        ret_data  = 32'hE1;
        @(negedge clk);
        ret_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        checkOutput("mid reset rd_req", rd_req, 0);
        checkOutput("mid reset data_ok", data_ok, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("post reset rd_req", rd_req, 0);
        checkOutput("post reset data_ok", data_ok, 0);
        missFill("post reset", 32'h0000_1008, 1'b0, 32'h0000_1000, 3'b100, 4, 32'hF0, 32'hF2);
        fetchHit("post reset hit", 32'h0000_100C, 32'hF3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
